xnorpop_dot_sequencer: RTL and testbench
========================================

# xnorpop_dot_sequencer

Sequencer for the 128-bit XNOR-popcount datapath, used as a binary-neural-net dot-product engine. It accepts a job descriptor giving a vector length in 128-bit words, then streams that many operand-word pairs through a registered XNOR-popcount stage and accumulates the counts. It returns the total popcount and the bipolar dot product (2·pop − 128·len) over a valid/ready result port. It sits between the activation/weight fetch logic and the neuron post-processing (threshold/batch-norm) stage.

## Interface
Parameters:
- LEN_W, 8, width of job length in words; maximum job is 2^LEN_W − 1 words
- ACC_W, LEN_W+8, width of popcount accumulator; must hold 128·(2^LEN_W − 1)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start_valid  in  1  job descriptor valid
- start_ready  out  1  job descriptor accepted when both high
- start_len  in  LEN_W  job length in words; 0 is legal
- in_valid  in  1  operand beat valid
- in_ready  out  1  operand beat accepted when both high
- inx  in  128  activation word
- iny  in  128  weight word
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when both high
- out_pop  out  ACC_W  total count of matching bit positions
- out_dot  out  ACC_W+1  signed bipolar dot product, 2·out_pop − 128·len
- busy  out  1  high in any state except IDLE

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start_ready=1. On a start handshake, latch len. Clear acc and the pipe valid flag.
  - len≠0 → RUN, with remaining=len.
  - len=0 → DONE, with acc=0.
- RUN: in_ready=1 while remaining>0. On each beat:
  - pop_q ← popcount(inx ~^ iny), range 0..128 in 8 bits; pop_v ← 1.
  - remaining decrements.
  - When the beat accepted has remaining==1 → DRAIN.
  - With in_valid low, nothing changes.
- Every cycle with pop_v=1: acc ← acc + pop_q, zero-extended to ACC_W.
- DRAIN: in_ready=0. The last pop_q is added → DONE.
- DONE: out_valid=1, out_pop=acc, out_dot=2·acc − 128·len, computed signed in ACC_W+1 bits with no overflow possible. The outputs hold stable until out_ready. On the handshake → IDLE.
- start_ready is 0 outside IDLE. A start request that arrives during DONE is accepted no earlier than the cycle after the result handshake.
- Extra in_valid beats beyond len are not accepted (in_ready=0); they wait for the next job.
- Reset at any point, including mid-job: state=IDLE and the in-flight job is discarded with no result.
- Reset values: state IDLE, start_ready=1, in_ready=0, out_valid=0, out_pop=0, out_dot=0, busy=0, acc=0, pop_v=0, remaining=0.

## Timing
- start_ready, in_ready, out_valid and busy are decoded from registered state only. There is no combinational path from any input to any handshake output.
- Throughput: one operand beat per cycle in RUN, with no bubbles.
- Latency: last beat accepted in cycle t → DRAIN in t+1 → out_valid in t+2.
- len=0: start accepted in cycle t → out_valid in t+1, out_pop=0, out_dot=0.
- Minimum job-to-job spacing: a result handshake in cycle t lets start_ready rise in t+1.
- The popcount tree runs combinationally from inx/iny to the pop_q register, which is one full cycle.

## Structure
- Package xnorpop_pkg:
  - WORD_W=128 and POP_W=8.
  - State enum {IDLE, RUN, DRAIN, DONE}.
  - A function for the bipolar conversion.
- Sub-module xnorpop128: purely combinational, 2×128 bits in, 8-bit popcount of the XNOR out. It is instantiated once, feeding pop_q.
- The top level holds the FSM, the remaining counter, pop_q/pop_v, acc and the result registers.

## Test plan
- len=1, inx=iny=all-ones, out_ready=1 → out_pop=128, out_dot=+128; out_valid 2 cycles after the beat.
- len=3, beats with inx=~iny each time → out_pop=0, out_dot=−384.
- len=2, beat 1 with 64 matching bits, beat 2 with 1 matching bit, in_valid gapped by 3 idle cycles → out_pop=65, out_dot=2·65−256=−126.
- len=0 → out_valid one cycle after start, out_pop=0, out_dot=0; in_ready never asserts.
- out_ready held low 5 cycles in DONE → outputs stable and start_ready=0 throughout. After the handshake, a back-to-back job with len=255 and all-matching inputs → out_pop=32640, out_dot=32640.
- rst pulsed mid-RUN after 4 of 10 beats → all outputs return to reset values immediately. A fresh len=1 job then yields a correct result, with no carry-over from acc.

Source files
------------

// File: rtl/xnorpop_pkg.sv
// rtl/xnorpop_pkg.sv - shared widths, state encoding and bipolar conversion for the XNOR-popcount sequencer
package xnorpop_pkg;

  localparam int WORD_W = 128;
  localparam int POP_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bipolar dot product 2*pop - 128*len; callers truncate to their result width.
  function automatic logic signed [63:0] bipolar(input logic [62:0] pop, input logic [62:0] len);
    logic signed [63:0] p;
    logic signed [63:0] l;
    p = $signed({1'b0, pop});
    l = $signed({1'b0, len});
    return (p <<< 1) - (l <<< 7);
  endfunction

endpackage

// File: rtl/xnorpop128.sv
// rtl/xnorpop128.sv - combinational popcount of the XNOR of two 128-bit words
module xnorpop128
  import xnorpop_pkg::*;
(
  input  logic [WORD_W-1:0] x,
  input  logic [WORD_W-1:0] y,
  output logic [POP_W-1:0]  pop
);

  logic [WORD_W-1:0] match;

  assign match = x ~^ y;

  always_comb begin
    pop = '0;
    for (int i = 0; i < WORD_W; i++) begin
      pop = pop + POP_W'(match[i]);
    end
  end

endmodule

// File: rtl/xnorpop_dot_sequencer.sv
// rtl/xnorpop_dot_sequencer.sv - job sequencer accumulating XNOR popcounts into a bipolar dot product
module xnorpop_dot_sequencer
  import xnorpop_pkg::*;
#(
  parameter int LEN_W = 8,
  parameter int ACC_W = LEN_W + 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  logic [LEN_W-1:0]        start_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_W-1:0]       inx,
  input  logic [WORD_W-1:0]       iny,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        out_pop,
  output logic signed [ACC_W:0]   out_dot,
  output logic                    busy
);

  state_t             state;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   remaining;
  logic [POP_W-1:0]   pop_q;
  logic               pop_v;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_next;
  logic [POP_W-1:0]   pop_word;
  logic               beat;

  xnorpop128 u_pop (
    .x   (inx),
    .y   (iny),
    .pop (pop_word)
  );

  // Handshake outputs depend only on registered state, never on inputs.
  assign start_ready = (state == IDLE);
  assign in_ready    = (state == RUN) && (remaining != '0);
  assign out_valid   = (state == DONE);
  assign busy        = (state != IDLE);

  assign beat     = in_ready && in_valid;
  assign acc_next = pop_v ? acc + ACC_W'(pop_q) : acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      len_q     <= '0;
      remaining <= '0;
      pop_q     <= '0;
      pop_v     <= 1'b0;
      acc       <= '0;
      out_pop   <= '0;
      out_dot   <= '0;
    end else begin
      pop_v <= beat;
      if (beat) begin
        pop_q <= pop_word;
      end
      acc <= acc_next;

      case (state)
        IDLE: begin
          if (start_valid) begin
            len_q <= start_len;
            acc   <= '0;
            pop_v <= 1'b0;
            if (start_len == '0) begin
              out_pop <= '0;
              out_dot <= '0;
              state   <= DONE;
            end else begin
              remaining <= start_len;
              state     <= RUN;
            end
          end
        end
        RUN: begin
          if (beat) begin
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // acc_next already includes the final beat's count.
          out_pop <= acc_next;
          out_dot <= (ACC_W+1)'(bipolar(63'(acc_next), 63'(len_q)));
          state   <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xnorpop_dot_sequencer.sv
// tb/tb_xnorpop_dot_sequencer.sv - directed self-checking bench for xnorpop_dot_sequencer
module tb_xnorpop_dot_sequencer;

  localparam int LEN_W = 8;
  localparam int ACC_W = 16;

  logic                  clk;
  logic                  rst;
  logic                  start_valid;
  logic                  start_ready;
  logic [LEN_W-1:0]      start_len;
  logic                  in_valid;
  logic                  in_ready;
  logic [127:0]          inx;
  logic [127:0]          iny;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_W-1:0]      out_pop;
  logic signed [ACC_W:0] out_dot;
  logic                  busy;

  int checks;
  int failures;

  localparam logic [127:0] ONES = {128{1'b1}};
  localparam logic [127:0] HALF = {{64{1'b1}}, {64{1'b0}}};

  xnorpop_dot_sequencer #(.LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .start_len   (start_len),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .inx         (inx),
    .iny         (iny),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pop     (out_pop),
    .out_dot     (out_dot),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (start_ready !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_handshake: sr=%b ir=%b ov=%b busy=%b want 1 0 0 0", start_ready, in_ready, out_valid, busy);
    end
    checks++;
    if (out_pop !== 16'd0 || out_dot !== 17'sd0) begin
      failures++;
      $display("FAIL reset_result: pop=%0d dot=%0d want 0 0", out_pop, out_dot);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single;
    start_len = 8'd1;
    start_valid = 1'b1;
    checks++;
    if (start_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_start_ready: got %b want 1", start_ready);
    end
    tick();
    start_valid = 1'b0;
    inx = ONES;
    iny = ONES;
    in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_in_ready: ir=%b busy=%b want 1 1", in_ready, busy);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_drain_ov: got %b want 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pop !== 16'd128 || out_dot !== 17'sd128) begin
      failures++;
      $display("FAIL single_result: ov=%b pop=%0d dot=%0d want 1 128 128", out_valid, out_pop, out_dot);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (start_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_return_idle: sr=%b busy=%b ov=%b want 1 0 0", start_ready, busy, out_valid);
    end
  endtask

  task automatic test_all_mismatch;
    int accepted;
    accepted = 0;
    start_len = 8'd3;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      inx = {4{32'hA5C3_0F96 + 32'(i)}};
      iny = ~inx;
      in_valid = 1'b1;
      if (in_ready === 1'b1) accepted++;
      tick();
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (accepted != 3) begin
      failures++;
      $display("FAIL mismatch_beats: accepted=%0d want 3", accepted);
    end
    checks++;
    if (out_valid !== 1'b1 || out_pop !== 16'd0 || out_dot !== -17'sd384) begin
      failures++;
      $display("FAIL mismatch_result: ov=%b pop=%0d dot=%0d want 1 0 -384", out_valid, out_pop, out_dot);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_gapped;
    start_len = 8'd2;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    inx = HALF;
    iny = ONES;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL gapped_idle_%0d: ir=%b ov=%b want 1 0", i, in_ready, out_valid);
      end
      tick();
    end
    inx = 128'h1;
    iny = ONES;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pop !== 16'd65 || out_dot !== -17'sd126) begin
      failures++;
      $display("FAIL gapped_result: ov=%b pop=%0d dot=%0d want 1 65 -126", out_valid, out_pop, out_dot);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_zero_len;
    start_len = 8'd0;
    start_valid = 1'b1;
    in_valid = 1'b1;
    inx = ONES;
    iny = ONES;
    tick();
    start_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_pop !== 16'd0 || out_dot !== 17'sd0) begin
      failures++;
      $display("FAIL zero_len_result: ov=%b pop=%0d dot=%0d want 1 0 0", out_valid, out_pop, out_dot);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL zero_len_in_ready: got %b want 0", in_ready);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || start_ready !== 1'b1) begin
      failures++;
      $display("FAIL zero_len_after: ir=%b sr=%b want 0 1", in_ready, start_ready);
    end
  endtask

  task automatic test_back_to_back;
    int accepted;
    logic stable_ok;
    start_len = 8'd1;
    start_valid = 1'b1;
    tick();
    inx = HALF;
    iny = ONES;
    in_valid = 1'b1;
    start_len = 8'd255;
    tick();
    in_valid = 1'b0;
    tick();
    stable_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || out_pop !== 16'd64 || out_dot !== 17'sd0 || start_ready !== 1'b0) begin
        stable_ok = 1'b0;
        $display("FAIL hold_cycle_%0d: ov=%b pop=%0d dot=%0d sr=%b want 1 64 0 0", i, out_valid, out_pop, out_dot, start_ready);
      end
      tick();
    end
    checks++;
    if (stable_ok !== 1'b1) begin
      failures++;
      $display("FAIL hold_stable: got %b want 1", stable_ok);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (start_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_start_ready: sr=%b ov=%b want 1 0", start_ready, out_valid);
    end
    tick();
    start_valid = 1'b0;
    accepted = 0;
    inx = ONES;
    iny = ONES;
    in_valid = 1'b1;
    for (int i = 0; i < 255; i++) begin
      if (in_ready === 1'b1) accepted++;
      tick();
    end
    checks++;
    if (accepted != 255) begin
      failures++;
      $display("FAIL b2b_throughput: accepted=%0d want 255", accepted);
    end
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_extra_beat: ir=%b ov=%b want 0 0", in_ready, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pop !== 16'd32640 || out_dot !== 17'sd32640 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_result: ov=%b pop=%0d dot=%0d ir=%b want 1 32640 32640 0", out_valid, out_pop, out_dot, in_ready);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    start_len = 8'd10;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    inx = ONES;
    iny = ONES;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (start_ready !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midrun_reset_hs: sr=%b ir=%b ov=%b busy=%b want 1 0 0 0", start_ready, in_ready, out_valid, busy);
    end
    checks++;
    if (out_pop !== 16'd0 || out_dot !== 17'sd0) begin
      failures++;
      $display("FAIL midrun_reset_result: pop=%0d dot=%0d want 0 0", out_pop, out_dot);
    end
    tick();
    rst = 1'b0;
    tick();
    start_len = 8'd1;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    inx = 128'h7;
    iny = ONES;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pop !== 16'd3 || out_dot !== -17'sd122) begin
      failures++;
      $display("FAIL post_reset_job: ov=%b pop=%0d dot=%0d want 1 3 -122", out_valid, out_pop, out_dot);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    start_valid = 1'b0;
    start_len = '0;
    in_valid = 1'b0;
    inx = '0;
    iny = '0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_all_mismatch();
    test_gapped();
    test_zero_len();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
